// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS pipeline memory stage.
// Holds the access-width encodings, the default datapath width, the
// register-index width, the MEM/WB control bundle and small helpers used
// by memory_access and its interface.
// No ports (package).

package mips_pkg;

    localparam int NB_DATA_DEF = 32;   // default datapath / address width
    localparam int NB_REG      = 5;    // register-index width
    localparam int NB_LANES    = 4;    // byte lanes per word (offset is 2 bits)

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_RSVD = 2'b10,            // decoded exactly like WIDTH_WORD
        WIDTH_WORD = 2'b11
    } width_e;

    // Control bits carried from EX/MEM into MEM/WB.
    typedef struct packed {
        logic              mem2reg;
        logic              reg_write;
        logic [NB_REG-1:0] write_reg;
        logic              misalign;
    } mem_wb_ctl_t;

    // Half needs an even offset, word (and reserved) needs offset 0.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
        case (width)
            WIDTH_BYTE: return 1'b0;
            WIDTH_HALF: return off[0];
            default:    return off != 2'b00;
        endcase
    endfunction

    // Lanes touched by an aligned access of the given width at the offset.
    function automatic logic [NB_LANES-1:0] lane_mask(input logic [1:0] width, input logic [1:0] off);
        case (width)
            WIDTH_BYTE: return 4'b0001 << off;
            WIDTH_HALF: return 4'b0011 << off;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if -- EX/MEM inputs and MEM/WB outputs of the memory stage.
// Parameter NB_DATA : datapath width (32 expected, four byte lanes).
// Modports:
//   master : pipeline side, drives i_* and samples o_*
//   slave  : memory_access side
// Signals: i_halt, i_mem2reg, i_memRead, i_memWrite, i_regWrite, i_width[1:0],
//          i_sign_flag, i_write_reg[4:0], i_result, i_data4Mem,
//          o_mem2reg, o_regWrite, o_write_reg[4:0], o_read_data, o_alu_result,
//          o_misalign.

interface memory_access_if #(
    parameter int NB_DATA = 32
);
    import mips_pkg::*;

    logic               i_halt;
    logic               i_mem2reg;
    logic               i_memRead;
    logic               i_memWrite;
    logic               i_regWrite;
    logic [1:0]         i_width;
    logic               i_sign_flag;
    logic [NB_REG-1:0]  i_write_reg;
    logic [NB_DATA-1:0] i_result;
    logic [NB_DATA-1:0] i_data4Mem;

    logic               o_mem2reg;
    logic               o_regWrite;
    logic [NB_REG-1:0]  o_write_reg;
    logic [NB_DATA-1:0] o_read_data;
    logic [NB_DATA-1:0] o_alu_result;
    logic               o_misalign;

    modport master (
        output i_halt, i_mem2reg, i_memRead, i_memWrite, i_regWrite,
               i_width, i_sign_flag, i_write_reg, i_result, i_data4Mem,
        input  o_mem2reg, o_regWrite, o_write_reg, o_read_data,
               o_alu_result, o_misalign
    );

    modport slave (
        input  i_halt, i_mem2reg, i_memRead, i_memWrite, i_regWrite,
               i_width, i_sign_flag, i_write_reg, i_result, i_data4Mem,
        output o_mem2reg, o_regWrite, o_write_reg, o_read_data,
               o_alu_result, o_misalign
    );

endinterface

// File: rtl/data_memory.sv
// data_memory -- byte-lane data RAM, 2^NB_ADDR words of four byte lanes.
// Optional feature macro: MEMORY_ACCESS_DEBUG_PORT_EN (adds debug read port).
// Ports:
//   clk       in   write clock (rising edge)
//   be        in   [3:0] per-lane write enable
//   addr      in   [NB_ADDR-1:0] word index for write and async read
//   wdata     in   [NB_DATA-1:0] lane-positioned write data
//   rdata     out  [NB_DATA-1:0] async read of word addr (pre-write value)
//   dbg_addr  in   [NB_ADDR-1:0] debug word index      (debug build only)
//   dbg_data  out  [NB_DATA-1:0] async read of dbg_addr (debug build only)
// Contents are never reset.

module data_memory
    import mips_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = 8
) (
    input  logic                clk,
    input  logic [NB_LANES-1:0] be,
    input  logic [NB_ADDR-1:0]  addr,
    input  logic [NB_DATA-1:0]  wdata,
    output logic [NB_DATA-1:0]  rdata
`ifdef MEMORY_ACCESS_DEBUG_PORT_EN
    ,
    input  logic [NB_ADDR-1:0]  dbg_addr,
    output logic [NB_DATA-1:0]  dbg_data
`endif
);

    localparam int DEPTH = 1 << NB_ADDR;

    // One independent byte array per lane keeps each lane's write enable local.
    for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
        logic [7:0] bytes [DEPTH];

        always_ff @(posedge clk) begin
            if (be[l]) bytes[addr] <= wdata[l*8 +: 8];
        end

        assign rdata[l*8 +: 8] = bytes[addr];
`ifdef MEMORY_ACCESS_DEBUG_PORT_EN
        assign dbg_data[l*8 +: 8] = bytes[dbg_addr];
`endif
    end

endmodule

// File: rtl/memory_access.sv
// memory_access -- MEM stage of the MIPS pipeline plus the MEM/WB register.
// Byte/half/word loads and stores into data_memory, load extension, misalign
// detection, halt freeze and async-reset of the MEM/WB outputs.
// Optional feature macro: MEMORY_ACCESS_DEBUG_PORT_EN.
// Ports:
//   clk         in   clock, rising edge
//   i_rst_n     in   asynchronous active-low reset (clears outputs, not memory)
//   bus         slave modport of memory_access_if (EX/MEM in, MEM/WB out)
//   i_dbg_addr  in   [NB_ADDR-1:0] debug word index       (debug build only)
//   o_dbg_data  out  [NB_DATA-1:0] addressed word, comb.  (debug build only)

module memory_access
    import mips_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = 8
) (
    input  logic                clk,
    input  logic                i_rst_n,
    memory_access_if.slave      bus
`ifdef MEMORY_ACCESS_DEBUG_PORT_EN
    ,
    input  logic [NB_ADDR-1:0]  i_dbg_addr,
    output logic [NB_DATA-1:0]  o_dbg_data
`endif
);

    // Address decode: upper result bits are ignored, so addresses wrap.
    logic [NB_ADDR-1:0] widx;
    logic [1:0]         off;
    logic               access;
    logic               bad_align;
    logic               misalign;
    logic               store_en;

    assign widx      = bus.i_result[NB_ADDR+1:2];
    assign off       = bus.i_result[1:0];
    assign access    = bus.i_memRead | bus.i_memWrite;
    assign bad_align = is_misaligned(bus.i_width, off);
    assign misalign  = access & bad_align;
    // Reset gates the write too, so a store coinciding with reset is dropped.
    assign store_en  = bus.i_memWrite & ~bad_align & ~bus.i_halt & i_rst_n;

    // Store data is replicated across lanes; the lane mask picks the live ones.
    logic [NB_LANES-1:0] be;
    logic [NB_DATA-1:0]  wdata;

    assign be = store_en ? lane_mask(bus.i_width, off) : '0;

    always_comb begin
        wdata = bus.i_data4Mem;
        case (bus.i_width)
            WIDTH_BYTE: wdata = {(NB_DATA/8){bus.i_data4Mem[7:0]}};
            WIDTH_HALF: wdata = {(NB_DATA/16){bus.i_data4Mem[15:0]}};
            default:    wdata = bus.i_data4Mem;
        endcase
    end

    logic [NB_DATA-1:0] rdata;

    data_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_mem (
        .clk      (clk),
        .be       (be),
        .addr     (widx),
        .wdata    (wdata),
        .rdata    (rdata)
`ifdef MEMORY_ACCESS_DEBUG_PORT_EN
        ,
        .dbg_addr (i_dbg_addr),
        .dbg_data (o_dbg_data)
`endif
    );

    // Load extraction. rdata is the pre-write word, so read+write in one
    // cycle returns the old contents.
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [NB_DATA-1:0] ld_ext;
    logic [NB_DATA-1:0] ld_next;

    always_comb begin
        ld_byte = rdata[{off, 3'b000} +: 8];
        ld_half = rdata[{off[1], 4'b0000} +: 16];
        ld_ext  = rdata;
        case (bus.i_width)
            WIDTH_BYTE: ld_ext = {{(NB_DATA-8){bus.i_sign_flag & ld_byte[7]}}, ld_byte};
            WIDTH_HALF: ld_ext = {{(NB_DATA-16){bus.i_sign_flag & ld_half[15]}}, ld_half};
            default:    ld_ext = rdata;
        endcase
    end

    assign ld_next = (bus.i_memRead & ~bad_align) ? ld_ext : '0;

    // MEM/WB register: async clear, frozen while halted.
    mem_wb_ctl_t        ctl_q;
    logic [NB_DATA-1:0] read_q;
    logic [NB_DATA-1:0] alu_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctl_q  <= '0;
            read_q <= '0;
            alu_q  <= '0;
        end else if (!bus.i_halt) begin
            ctl_q.mem2reg   <= bus.i_mem2reg;
            ctl_q.reg_write <= bus.i_regWrite;
            ctl_q.write_reg <= bus.i_write_reg;
            ctl_q.misalign  <= misalign;
            read_q          <= ld_next;
            alu_q           <= bus.i_result;
        end
    end

    assign bus.o_mem2reg    = ctl_q.mem2reg;
    assign bus.o_regWrite   = ctl_q.reg_write;
    assign bus.o_write_reg  = ctl_q.write_reg;
    assign bus.o_misalign   = ctl_q.misalign;
    assign bus.o_read_data  = read_q;
    assign bus.o_alu_result = alu_q;

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access -- self-checking bench for memory_access.
// A byte-array model of the memory predicts the MEM/WB outputs each cycle;
// directed sequences pin known literal results, then random traffic runs.

module tb_memory_access;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 8;
    localparam int DEPTH   = 1 << NB_ADDR;
    localparam int MEMB    = DEPTH * 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    memory_access_if #(.NB_DATA(NB_DATA)) bus ();

`ifdef MEMORY_ACCESS_DEBUG_PORT_EN
    logic [NB_ADDR-1:0] dbg_addr = '0;
    logic [NB_DATA-1:0] dbg_data;
`endif

    memory_access #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) dut (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .bus        (bus.slave)
`ifdef MEMORY_ACCESS_DEBUG_PORT_EN
        ,
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
`endif
    );

    // Reference model: flat byte memory, little-endian words.
    logic [7:0]  mm [MEMB];
    logic        e_m2r, e_rw, e_mis;
    logic [4:0]  e_wr;
    logic [31:0] e_rd, e_alu;
    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_val(input int unsigned a, input int n, input bit sgn);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[(a + i) % MEMB];
        if (sgn && n < 4 && v[8*n-1])
            for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
        return v;
    endfunction

    task automatic model_step();
        int unsigned a;
        int          n;
        bit          mis;
        if (!rst_n) begin
            e_m2r = 0; e_rw = 0; e_mis = 0; e_wr = '0; e_rd = '0; e_alu = '0;
        end else if (!bus.i_halt) begin
            a   = bus.i_result % MEMB;
            n   = (bus.i_width == 2'b00) ? 1 : (bus.i_width == 2'b01) ? 2 : 4;
            mis = (bus.i_memRead || bus.i_memWrite) && (a % n != 0);
            e_rd = (bus.i_memRead && !mis) ? load_val(a, n, bus.i_sign_flag) : 32'h0;
            if (bus.i_memWrite && !mis)
                for (int i = 0; i < n; i++) mm[a + i] = bus.i_data4Mem[8*i +: 8];
            e_mis = mis;
            e_m2r = bus.i_mem2reg;
            e_rw  = bus.i_regWrite;
            e_wr  = bus.i_write_reg;
            e_alu = bus.i_result;
        end
    endtask

    // Single compare process: model advances on the edge, DUT sampled 1 later.
    always @(posedge clk) begin
        model_step();
        #1;
        if (chk_en) begin
            chk("read_data", bus.o_read_data, e_rd);
            chk("alu_result", bus.o_alu_result, e_alu);
            chk("misalign", bus.o_misalign, e_mis);
            chk("write_reg", bus.o_write_reg, e_wr);
            chk("regWrite", bus.o_regWrite, e_rw);
            chk("mem2reg", bus.o_mem2reg, e_m2r);
`ifdef MEMORY_ACCESS_DEBUG_PORT_EN
            chk("dbg_data", dbg_data, {mm[4*dbg_addr+3], mm[4*dbg_addr+2],
                                       mm[4*dbg_addr+1], mm[4*dbg_addr]});
`endif
        end
    end

    task automatic drive(input bit rd, input bit wr, input logic [1:0] w, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] data, input bit halt);
        @(negedge clk);
        bus.i_memRead   = rd;
        bus.i_memWrite  = wr;
        bus.i_width     = w;
        bus.i_sign_flag = sgn;
        bus.i_result    = addr;
        bus.i_data4Mem  = data;
        bus.i_halt      = halt;
        bus.i_write_reg = 5'($urandom);
        bus.i_mem2reg   = 1'($urandom);
        bus.i_regWrite  = 1'($urandom);
`ifdef MEMORY_ACCESS_DEBUG_PORT_EN
        dbg_addr = NB_ADDR'($urandom);
`endif
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] r;
        bus.i_memRead = 0; bus.i_memWrite = 0; bus.i_width = 2'b11; bus.i_sign_flag = 0;
        bus.i_result = '0; bus.i_data4Mem = '0; bus.i_halt = 0; bus.i_write_reg = '0;
        bus.i_mem2reg = 0; bus.i_regWrite = 0;

        // Reset state.
        #1 rst_n = 1'b0;
        #2;
        chk("rst read_data", bus.o_read_data, 32'h0);
        chk("rst alu_result", bus.o_alu_result, 32'h0);
        chk("rst misalign", bus.o_misalign, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clear the whole memory so every later load has a known value.
        for (int i = 0; i < DEPTH; i++) drive(0, 1, 2'b11, 0, 32'(i * 4), 32'h0, 0);
        chk_en = 1;

        // Word store then load, back to back.
        drive(0, 1, 2'b11, 0, 32'h10, 32'hDEADBEEF, 0);
        drive(1, 0, 2'b11, 0, 32'h10, 32'h0, 0);
        chk("lit word load", bus.o_read_data, 32'hDEADBEEF);

        // Byte store into lane 3, signed/unsigned loads.
        drive(0, 1, 2'b00, 0, 32'h13, 32'h00000080, 0);
        drive(1, 0, 2'b00, 1, 32'h13, 32'h0, 0);
        chk("lit byte signed", bus.o_read_data, 32'hFFFFFF80);
        drive(1, 0, 2'b00, 0, 32'h13, 32'h0, 0);
        chk("lit byte unsigned", bus.o_read_data, 32'h00000080);
        drive(1, 0, 2'b11, 0, 32'h10, 32'h0, 0);
        chk("lit word merged", bus.o_read_data, 32'h80ADBEEF);

        // Misaligned half load and word store.
        drive(1, 0, 2'b01, 1, 32'h11, 32'h0, 0);
        chk("lit misalign half", bus.o_misalign, 1'b1);
        chk("lit misalign data", bus.o_read_data, 32'h0);
        drive(0, 1, 2'b11, 0, 32'h12, 32'h12345678, 0);
        chk("lit misalign store", bus.o_misalign, 1'b1);
        drive(1, 0, 2'b11, 0, 32'h10, 32'h0, 0);
        chk("lit store suppressed", bus.o_read_data, 32'h80ADBEEF);

        // Halt freezes outputs and blocks the store.
        drive(1, 1, 2'b11, 0, 32'h20, 32'h12345678, 1);
        chk("lit halt read_data", bus.o_read_data, 32'h80ADBEEF);
        chk("lit halt alu", bus.o_alu_result, 32'h10);
        drive(1, 0, 2'b11, 0, 32'h20, 32'h0, 0);
        chk("lit halt no store", bus.o_read_data, 32'h0);

        // Reserved width acts as word.
        drive(1, 0, 2'b10, 0, 32'h10, 32'h0, 0);
        chk("lit width10", bus.o_read_data, 32'h80ADBEEF);

        // Async reset mid-cycle, store during reset is dropped, memory kept.
        drive(0, 1, 2'b11, 0, 32'h04, 32'hCAFEF00D, 0);
        drive(1, 0, 2'b11, 0, 32'h10, 32'h0, 0);
        @(negedge clk);
        #2;
        bus.i_memRead = 0; bus.i_memWrite = 1; bus.i_width = 2'b11;
        bus.i_result = 32'h04; bus.i_data4Mem = 32'h11111111;
        rst_n = 1'b0;
        #1;
        chk("async rst read_data", bus.o_read_data, 32'h0);
        chk("async rst alu", bus.o_alu_result, 32'h0);
        chk("async rst misalign", bus.o_misalign, 1'b0);
        chk("async rst write_reg", bus.o_write_reg, 5'h0);
        chk("async rst regWrite", bus.o_regWrite, 1'b0);
        chk("async rst mem2reg", bus.o_mem2reg, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.i_memWrite = 0;
        rst_n = 1'b1;
        drive(1, 0, 2'b11, 0, 32'h04, 32'h0, 0);
        chk("lit mem retained", bus.o_read_data, 32'hCAFEF00D);

        // Read and write together return the old word.
        drive(1, 1, 2'b11, 0, 32'h08, 32'h55AA55AA, 0);
        chk("lit rw old", bus.o_read_data, 32'h0);
        drive(1, 0, 2'b11, 0, 32'h08, 32'h0, 0);
        chk("lit rw new", bus.o_read_data, 32'h55AA55AA);

        // Random traffic; upper address bits random to exercise wrap-around.
        repeat (3000) begin
            r = $urandom;
            case ($urandom_range(0, 2))
                0:       r[1:0] = 2'b00;
                1:       r[0]   = 1'b0;
                default: ;
            endcase
            drive(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), r, $urandom,
                  ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
